ibex_fetch_aligner: RTL

IBEX_FETCH_ALIGNER -- requirements
Module: ibex_fetch_aligner

---
 rtl/ibex_fetch_aligner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_aligner.sv
// Realigns a word-aligned fetch stream into 16/32-bit instructions for the decoder.
// Mixed compressed and full instructions, including ones straddling two words, flow without bubbles.
module ibex_fetch_aligner #(
  parameter logic [31:0] ResetPc = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o
);

  typedef enum logic [1:0] {
    ALIGNED,
    HALF,
    SKIP,
    ERROR
  } state_e;

  localparam state_e ResetState = ResetPc[1] ? SKIP : ALIGNED;

  state_e      state_q, state_d;
  logic [15:0] res_q, res_d;
  logic [31:1] pc_q, pc_d;

  logic        valid_c;
  logic        err_c;
  logic        accept;
  logic        consume;
  logic        word_is_c;
  logic        res_is_c;
  logic        unused_redirect_pc0;

  assign unused_redirect_pc0 = redirect_pc_i[0];
  assign word_is_c = (fetch_rdata_i[1:0] != 2'b11);
  assign res_is_c  = (res_q[1:0] != 2'b11);

  // Output path: purely combinational from state and the current fetch word.
  always_comb begin
    valid_c       = 1'b0;
    err_c         = 1'b0;
    fetch_ready_o = 1'b0;
    out_instr_o   = 32'h0;
    if (!redirect_i) begin
      unique case (state_q)
        ALIGNED: begin
          out_instr_o   = word_is_c ? {16'h0, fetch_rdata_i[15:0]} : fetch_rdata_i;
          valid_c       = fetch_valid_i;
          fetch_ready_o = out_ready_i;
          err_c         = fetch_err_i;
        end
        HALF: begin
          if (res_is_c) begin
            // Residual halfword is a complete instruction; the fetch word is left untouched.
            out_instr_o = {16'h0, res_q};
            valid_c     = 1'b1;
          end else begin
            out_instr_o   = {fetch_rdata_i[15:0], res_q};
            valid_c       = fetch_valid_i;
            fetch_ready_o = out_ready_i;
            err_c         = fetch_err_i;
          end
        end
        SKIP:    fetch_ready_o = 1'b1;
        ERROR:   fetch_ready_o = 1'b1;
        default: fetch_ready_o = 1'b0;
      endcase
    end
  end

  assign out_valid_o         = valid_c & rst_ni;
  assign out_err_o           = err_c & rst_ni;
  assign out_pc_o            = {pc_q, 1'b0};
  assign out_is_compressed_o = (out_instr_o[1:0] != 2'b11);

  assign accept  = out_valid_o & out_ready_i;
  assign consume = fetch_valid_i & fetch_ready_o;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    pc_d    = pc_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i[31:1];
      res_d   = 16'h0;
      state_d = redirect_pc_i[1] ? SKIP : ALIGNED;
    end else begin
      unique case (state_q)
        ALIGNED: begin
          if (accept) begin
            if (word_is_c) begin
              res_d   = fetch_rdata_i[31:16];
              state_d = HALF;
              pc_d    = pc_q + 31'd1;
            end else begin
              pc_d    = pc_q + 31'd2;
            end
            if (fetch_err_i) state_d = ERROR;
          end
        end
        HALF: begin
          if (accept) begin
            if (res_is_c) begin
              state_d = ALIGNED;
              pc_d    = pc_q + 31'd1;
            end else begin
              res_d   = fetch_rdata_i[31:16];
              pc_d    = pc_q + 31'd2;
              if (fetch_err_i) state_d = ERROR;
            end
          end
        end
        SKIP: begin
          if (consume) begin
            res_d   = fetch_rdata_i[31:16];
            state_d = fetch_err_i ? ERROR : HALF;
          end
        end
        ERROR:   state_d = ERROR;
        default: state_d = ResetState;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetState;
      res_q   <= 16'h0;
      pc_q    <= ResetPc[31:1];
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
    end
  end

endmodule
